// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative unsigned multiply (shift-add) / divide (restoring) unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 mode,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_out;
    logic               r_busy;
    logic               r_ready;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;

    // Multiply: r_acc = {product_hi, multiplier/product_lo}; the carry out of
    // the add is the extra accumulator bit and is shifted straight back in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {remainder, quotient}; the shifted remainder needs one
    // extra bit so the trial compare is exact even for a zero divisor.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ok   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = {(w_div_ok ? w_rem_diff : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid && !abort) begin
                        r_cnt   <= '0;
                        r_opnd  <= mode ? in_B : in_A;
                        r_acc   <= {{WIDTH{1'b0}}, (mode ? in_A : in_B)};
                        r_state <= mode ? S_DIV : S_MULT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_MULT, S_DIV: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= (r_state == S_MULT) ? w_mul_next : w_div_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= S_OUT;
                        end
                    end
                end
                // busy stays high one more cycle so it covers the ready pulse
                S_OUT: begin
                    r_out   <= r_acc;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;
    assign out   = r_out;

endmodule

`default_nettype wire
